game_tick_scheduler: RTL and testbench
======================================

Name: game_tick_scheduler

Overview:
Central timing controller for the SpacyBird game datapath.
- Converts the per-frame sync pulse into single-cycle move strobes for the pipe and bird position blocks.
- Sequences game phases: idle, start countdown, run, pause, game over.
- Raises pipe speed level from the current score.
- Issues the round-reset pulse that clears the pipe, window, score and bird blocks.

Parameters:
CNT_FRAMES, 60, frames per countdown step (one second at 60 Hz)
LEVELS, 4, number of speed levels (at least 2)
SCORE_STEP, 5, score points per speed level increase

Ports:
iClk  in  1  system clock
iRst  in  1  asynchronous active-low reset
iFrameSync  in  1  one-cycle pulse per video frame
iStart  in  1  one-cycle pulse, ENTER rising edge
iPause  in  1  one-cycle pulse, pause toggle
iBirdDead  in  1  level, bird collision latched
iScore  in  8  current score
oState  out  3  phase: IDLE=0, COUNTDOWN=1, RUN=2, PAUSE=3, OVER=4
oRoundRst  out  1  one-cycle pulse at round start
oPipeStep  out  1  one-cycle pipe move strobe
oBirdStep  out  1  one-cycle bird move strobe
oLevel  out  $clog2(LEVELS)  current speed level
oCountdown  out  2  countdown digit, 3..0
oGameOver  out  1  high in OVER

Behaviour:
- Reset (iRst=0, asynchronous) sets:
  - state IDLE
  - oRoundRst, oPipeStep, oBirdStep, oGameOver = 0
  - oLevel = 0, oCountdown = 0
  - frame counter and pipe divider = 0
- All outputs are registered.
- IDLE:
  - iStart moves to COUNTDOWN, pulses oRoundRst for 1 cycle (the cycle after iStart).
  - Loads oCountdown=3, clears frame counter, pipe divider and oLevel.
- COUNTDOWN:
  - Each iFrameSync increments the frame counter.
  - At CNT_FRAMES-1 the counter wraps to 0 and oCountdown decrements.
  - Wrap while oCountdown=1 sets oCountdown=0 and moves to RUN.
  - No step strobes are issued.
  - iStart and iPause are ignored.
- RUN, on iFrameSync:
  - oBirdStep=1 in the next cycle (latency 1).
  - Pipe divider counts 0..(LEVELS-1-oLevel).
  - oPipeStep=1 in the next cycle when divider==0, then divider increments or wraps to 0.
  - At level LEVELS-1 the pipe steps every frame; at level 0 it steps every LEVELS frames.
- Level update, only on iFrameSync in RUN:
  - oLevel = number of k in 1..LEVELS-1 with iScore >= k*SCORE_STEP.
  - Comparator chain against constants; no divider.
  - oLevel never decreases within a round; it clears only at round start.
  - If the level changes while divider > new maximum, the divider wraps to 0 on its next increment.
- PAUSE:
  - Entered from RUN on iPause; iPause in PAUSE returns to RUN.
  - In PAUSE: no strobes; frame counter, divider and level are held.
- OVER:
  - Entered from RUN or PAUSE when iBirdDead=1; oGameOver=1.
  - iStart goes to COUNTDOWN with oRoundRst pulse, identical to the IDLE start; oGameOver clears in the same cycle.
  - iBirdDead is ignored in IDLE, COUNTDOWN and OVER, because the bird block is in reset there.
- Priority in the same cycle: iBirdDead > iPause > iFrameSync.
  - iBirdDead with iFrameSync in RUN: no strobe, go to OVER.
  - iPause with iFrameSync in RUN: no strobe, go to PAUSE, divider unchanged.
- iStart is ignored in COUNTDOWN, RUN and PAUSE.
- Step strobes are never high for more than one cycle, and never outside RUN.
- Reset mid-round returns to IDLE immediately; no oRoundRst is issued by reset.

Decomposition:
- Shared package:
  - phase encoding constants IDLE/COUNTDOWN/RUN/PAUSE/OVER
  - state width 3
  - countdown start value 3
- Sub-module step_divider:
  - holds the pipe divider counter and level-dependent terminal compare
  - inputs: tick, hold, clear, level
  - output: step pulse

Test Plan:
1. Reset, iStart pulse, CNT_FRAMES=4 with 12 iFrameSync pulses -> oRoundRst one cycle after iStart; oCountdown 3,2,1; RUN after the 12th frame; no strobes during countdown.
2. RUN with iScore=0, LEVELS=4, 8 frames -> 8 oBirdStep, oPipeStep on frames 1 and 5 only, each 1 cycle wide, 1 cycle after iFrameSync.
3. iScore set to 15, SCORE_STEP=5 -> oLevel=3 after the next frame; oPipeStep on every frame. Then iScore=4 -> oLevel stays 3.
4. iPause in RUN, 5 frames, iPause again -> oState=3, zero strobes while paused; divider phase resumes unchanged.
5. iBirdDead and iFrameSync in the same cycle in RUN -> no strobe, oState=4, oGameOver=1. Then iStart -> oRoundRst pulse, oLevel=0, oCountdown=3, oGameOver=0.
6. iRst low mid-COUNTDOWN -> all outputs 0 asynchronously, oState=0, no oRoundRst after release.

Source files
------------

// File: rtl/game_tick_scheduler_pkg.sv
// Shared phase encoding and constants for the SpacyBird tick scheduler.
// Also holds the constant-comparator score-to-level helper.
package game_tick_scheduler_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RUN       = 3'd2,
    PAUSE     = 3'd3,
    OVER      = 3'd4
  } phase_t;

  localparam logic [1:0] COUNT_START = 2'd3;

  // Counts thresholds k*step (k = 1..levels-1) met by the score; unrolls to comparators.
  function automatic int scoreLevel(logic [7:0] score, int levels, int step);
    int lvl;
    lvl = 0;
    for (int k = 1; k < levels; k++) begin
      if (int'(score) >= k * step) lvl++;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/game_tick_scheduler_step_divider.sv
// Pipe step divider: pulses on every (LEVELS-level)th tick, starting with the first.
// Latency 1 cycle from tick to step; hold freezes the count, clear restarts the phase.
module step_divider #(
  parameter int LEVELS = 4,
  parameter int LW     = $clog2(LEVELS)
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iTick,
  input  logic          iHold,
  input  logic          iClear,
  input  logic [LW-1:0] iLevel,
  output logic          oStep
);

  logic [LW-1:0] divCnt;
  logic [LW-1:0] maxCnt;

  assign maxCnt = LW'(LEVELS - 1) - iLevel;

  // ">=" rather than "==" so a count stranded above a freshly lowered maximum still wraps.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      divCnt <= '0;
      oStep  <= 1'b0;
    end else if (iClear) begin
      divCnt <= '0;
      oStep  <= 1'b0;
    end else if (iTick && !iHold) begin
      oStep  <= (divCnt == '0);
      divCnt <= (divCnt >= maxCnt) ? '0 : divCnt + LW'(1);
    end else begin
      oStep  <= 1'b0;
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Game phase sequencer: countdown, run/pause/over, frame-synced bird and pipe strobes.
// Strobes and round reset appear 1 cycle after the causing input; no backpressure.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int CNT_FRAMES = 60,
  parameter int LEVELS     = 4,
  parameter int SCORE_STEP = 5
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iFrameSync,
  input  logic                      iStart,
  input  logic                      iPause,
  input  logic                      iBirdDead,
  input  logic [7:0]                iScore,
  output logic [2:0]                oState,
  output logic                      oRoundRst,
  output logic                      oPipeStep,
  output logic                      oBirdStep,
  output logic [$clog2(LEVELS)-1:0] oLevel,
  output logic [1:0]                oCountdown,
  output logic                      oGameOver
);

  localparam int LW = $clog2(LEVELS);
  localparam int FW = (CNT_FRAMES > 1) ? $clog2(CNT_FRAMES) : 1;

  phase_t        state, nextState;
  logic [FW-1:0] frameCnt, frameNext;
  logic [1:0]    countNext;
  logic [LW-1:0] levelNext;
  logic          roundRstNext, birdStepNext, gameOverNext;
  logic          startEv, runTick, frameLast;
  int            lvlCand;

  assign startEv   = iStart && (state == IDLE || state == OVER);
  assign runTick   = (state == RUN) && iFrameSync && !iBirdDead && !iPause;
  assign frameLast = (frameCnt == FW'(CNT_FRAMES - 1));
  assign oState    = state;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, OVER: if (iStart) nextState = COUNTDOWN;
      COUNTDOWN:  if (iFrameSync && frameLast && oCountdown == 2'd1) nextState = RUN;
      RUN: begin
        if (iBirdDead)   nextState = OVER;
        else if (iPause) nextState = PAUSE;
      end
      PAUSE: begin
        if (iBirdDead)   nextState = OVER;
        else if (iPause) nextState = RUN;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    frameNext    = frameCnt;
    countNext    = oCountdown;
    levelNext    = oLevel;
    lvlCand      = scoreLevel(iScore, LEVELS, SCORE_STEP);
    roundRstNext = startEv;
    birdStepNext = runTick;
    gameOverNext = (nextState == OVER);
    if (startEv) begin
      frameNext = '0;
      countNext = COUNT_START;
      levelNext = '0;
    end else if (state == COUNTDOWN && iFrameSync) begin
      frameNext = frameLast ? '0 : frameCnt + FW'(1);
      if (frameLast) countNext = oCountdown - 2'd1;
    end
    // Level only ratchets upward within a round.
    if (runTick && lvlCand > int'(oLevel)) levelNext = LW'(lvlCand);
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      frameCnt   <= '0;
      oCountdown <= '0;
      oLevel     <= '0;
      oRoundRst  <= 1'b0;
      oBirdStep  <= 1'b0;
      oGameOver  <= 1'b0;
    end else begin
      frameCnt   <= frameNext;
      oCountdown <= countNext;
      oLevel     <= levelNext;
      oRoundRst  <= roundRstNext;
      oBirdStep  <= birdStepNext;
      oGameOver  <= gameOverNext;
    end
  end

  step_divider #(.LEVELS(LEVELS)) uDivider (
    .iClk   (iClk),
    .iRst   (iRst),
    .iTick  (runTick),
    .iHold  (state != RUN),
    .iClear (startEv),
    .iLevel (oLevel),
    .oStep  (oPipeStep)
  );

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with CNT_FRAMES=4, LEVELS=4, SCORE_STEP=5.
module tb_game_tick_scheduler;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic       iFrameSync = 1'b0;
  logic       iStart = 1'b0;
  logic       iPause = 1'b0;
  logic       iBirdDead = 1'b0;
  logic [7:0] iScore = 8'd0;
  logic [2:0] oState;
  logic       oRoundRst, oPipeStep, oBirdStep, oGameOver;
  logic [1:0] oLevel;
  logic [1:0] oCountdown;

  int total = 0;
  int bad = 0;

  game_tick_scheduler #(.CNT_FRAMES(4), .LEVELS(4), .SCORE_STEP(5)) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iFrameSync (iFrameSync),
    .iStart     (iStart),
    .iPause     (iPause),
    .iBirdDead  (iBirdDead),
    .iScore     (iScore),
    .oState     (oState),
    .oRoundRst  (oRoundRst),
    .oPipeStep  (oPipeStep),
    .oBirdStep  (oBirdStep),
    .oLevel     (oLevel),
    .oCountdown (oCountdown),
    .oGameOver  (oGameOver)
  );

  always #5 iClk = ~iClk;

  task automatic cyc();
    @(posedge iClk); #1;
  endtask

  // One frame pulse: returns strobes in the cycle after the pulse and the cycle after that.
  task automatic frame(output logic b, output logic p, output logic b2, output logic p2);
    iFrameSync = 1'b1; cyc(); iFrameSync = 1'b0;
    b = oBirdStep; p = oPipeStep;
    cyc();
    b2 = oBirdStep; p2 = oPipeStep;
  endtask

  task automatic test_reset();
    #2;
    total++; if (oState !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", oState); end
    total++; if ({oRoundRst, oPipeStep, oBirdStep, oGameOver} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {oRoundRst, oPipeStep, oBirdStep, oGameOver}); end
    total++; if ({oLevel, oCountdown} !== 4'b0) begin bad++; $display("FAIL reset_level_cd got=%b exp=0000", {oLevel, oCountdown}); end
    cyc(); cyc();
    iRst = 1'b1;
    cyc();
  endtask

  task automatic test_countdown();
    logic b, p, b2, p2;
    int strobes = 0;
    iStart = 1'b1; cyc(); iStart = 1'b0;
    total++; if (oRoundRst !== 1'b1) begin bad++; $display("FAIL start_roundrst got=%b exp=1", oRoundRst); end
    total++; if (oState !== 3'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", oState); end
    total++; if (oCountdown !== 2'd3) begin bad++; $display("FAIL start_cd got=%0d exp=3", oCountdown); end
    cyc();
    total++; if (oRoundRst !== 1'b0) begin bad++; $display("FAIL roundrst_width got=%b exp=0", oRoundRst); end
    for (int i = 1; i <= 12; i++) begin
      frame(b, p, b2, p2);
      strobes += int'(b) + int'(p) + int'(b2) + int'(p2);
      total++; if (oCountdown !== 2'(3 - i / 4)) begin bad++; $display("FAIL cd_frame%0d got=%0d exp=%0d", i, oCountdown, 3 - i / 4); end
      total++; if (oState !== ((i == 12) ? 3'd2 : 3'd1)) begin bad++; $display("FAIL cd_state%0d got=%0d exp=%0d", i, oState, (i == 12) ? 2 : 1); end
    end
    total++; if (strobes != 0) begin bad++; $display("FAIL cd_strobes got=%0d exp=0", strobes); end
  endtask

  task automatic test_run_level0();
    logic b, p, b2, p2;
    iScore = 8'd0;
    for (int i = 1; i <= 8; i++) begin
      frame(b, p, b2, p2);
      total++; if (b !== 1'b1) begin bad++; $display("FAIL run_bird%0d got=%b exp=1", i, b); end
      total++; if (p !== ((i == 1 || i == 5) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL run_pipe%0d got=%b exp=%0d", i, p, (i == 1 || i == 5)); end
      total++; if ({b2, p2} !== 2'b00) begin bad++; $display("FAIL run_width%0d got=%b exp=00", i, {b2, p2}); end
    end
    total++; if (oLevel !== 2'd0) begin bad++; $display("FAIL run_level got=%0d exp=0", oLevel); end
  endtask

  task automatic test_pause();
    logic b, p, b2, p2;
    logic [2:0] expPipe;
    int strobes = 0;
    // Divider is back at phase 0: two frames -> step then none.
    frame(b, p, b2, p2);
    total++; if (p !== 1'b1) begin bad++; $display("FAIL pre_pause_pipe1 got=%b exp=1", p); end
    frame(b, p, b2, p2);
    total++; if (p !== 1'b0) begin bad++; $display("FAIL pre_pause_pipe2 got=%b exp=0", p); end
    // Pause coincident with a frame: pause wins, no strobe.
    iPause = 1'b1; iFrameSync = 1'b1; cyc(); iPause = 1'b0; iFrameSync = 1'b0;
    total++; if (oState !== 3'd3) begin bad++; $display("FAIL pause_state got=%0d exp=3", oState); end
    total++; if ({oBirdStep, oPipeStep} !== 2'b00) begin bad++; $display("FAIL pause_entry_strobe got=%b exp=00", {oBirdStep, oPipeStep}); end
    for (int i = 0; i < 5; i++) begin
      frame(b, p, b2, p2);
      strobes += int'(b) + int'(p) + int'(b2) + int'(p2);
    end
    total++; if (strobes != 0) begin bad++; $display("FAIL paused_strobes got=%0d exp=0", strobes); end
    iStart = 1'b1; cyc(); iStart = 1'b0;
    total++; if (oRoundRst !== 1'b0) begin bad++; $display("FAIL pause_start_ignored got=%b exp=0", oRoundRst); end
    iPause = 1'b1; cyc(); iPause = 1'b0;
    total++; if (oState !== 3'd2) begin bad++; $display("FAIL resume_state got=%0d exp=2", oState); end
    // Divider held at 2: steps resume on the third frame.
    expPipe = 3'b100;
    for (int i = 0; i < 3; i++) begin
      frame(b, p, b2, p2);
      total++; if (p !== expPipe[i]) begin bad++; $display("FAIL resume_pipe%0d got=%b exp=%b", i, p, expPipe[i]); end
    end
  endtask

  task automatic test_level();
    logic b, p, b2, p2;
    logic [5:0] expPipe;
    // Divider at 1, level 0 -> 3: one more idle frame while it wraps, then every frame.
    iScore = 8'd15;
    expPipe = 6'b111100;
    for (int i = 0; i < 6; i++) begin
      frame(b, p, b2, p2);
      total++; if (p !== expPipe[i]) begin bad++; $display("FAIL level_pipe%0d got=%b exp=%b", i, p, expPipe[i]); end
      total++; if (oLevel !== 2'd3) begin bad++; $display("FAIL level_val%0d got=%0d exp=3", i, oLevel); end
    end
    iScore = 8'd4;
    frame(b, p, b2, p2);
    total++; if (oLevel !== 2'd3) begin bad++; $display("FAIL level_no_drop got=%0d exp=3", oLevel); end
    total++; if ({b, p} !== 2'b11) begin bad++; $display("FAIL level_max_strobes got=%b exp=11", {b, p}); end
  endtask

  task automatic test_dead();
    iBirdDead = 1'b1; iFrameSync = 1'b1; cyc(); iFrameSync = 1'b0;
    total++; if ({oBirdStep, oPipeStep} !== 2'b00) begin bad++; $display("FAIL dead_strobe got=%b exp=00", {oBirdStep, oPipeStep}); end
    total++; if (oState !== 3'd4) begin bad++; $display("FAIL dead_state got=%0d exp=4", oState); end
    total++; if (oGameOver !== 1'b1) begin bad++; $display("FAIL dead_gameover got=%b exp=1", oGameOver); end
    cyc();
    iStart = 1'b1; cyc(); iStart = 1'b0; iBirdDead = 1'b0;
    total++; if (oRoundRst !== 1'b1) begin bad++; $display("FAIL restart_roundrst got=%b exp=1", oRoundRst); end
    total++; if (oLevel !== 2'd0) begin bad++; $display("FAIL restart_level got=%0d exp=0", oLevel); end
    total++; if (oCountdown !== 2'd3) begin bad++; $display("FAIL restart_cd got=%0d exp=3", oCountdown); end
    total++; if (oGameOver !== 1'b0) begin bad++; $display("FAIL restart_gameover got=%b exp=0", oGameOver); end
    total++; if (oState !== 3'd1) begin bad++; $display("FAIL restart_state got=%0d exp=1", oState); end
  endtask

  task automatic test_reset_mid();
    logic b, p, b2, p2;
    int rr = 0;
    frame(b, p, b2, p2);
    frame(b, p, b2, p2);
    #2 iRst = 1'b0;
    #1;
    total++; if (oState !== 3'd0) begin bad++; $display("FAIL midrst_state got=%0d exp=0", oState); end
    total++; if ({oRoundRst, oPipeStep, oBirdStep, oGameOver, oLevel, oCountdown} !== 8'b0) begin bad++; $display("FAIL midrst_outputs got=%b exp=00000000", {oRoundRst, oPipeStep, oBirdStep, oGameOver, oLevel, oCountdown}); end
    cyc(); iRst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      rr += int'(oRoundRst);
    end
    total++; if (rr != 0) begin bad++; $display("FAIL midrst_roundrst got=%0d exp=0", rr); end
    frame(b, p, b2, p2);
    total++; if ({b, p, oState} !== 5'b0) begin bad++; $display("FAIL idle_frame got=%b exp=00000", {b, p, oState}); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_run_level0();
    test_pause();
    test_level();
    test_dead();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
